// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: state encoding and shared constants for the pipeline hazard controller.
`default_nettype none

package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  localparam logic [4:0]  REG_X0          = 5'd0;
  localparam int unsigned MEM_TIMEOUT_DEF = 16;

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_detect.sv
// pipe_hazard_detect: load-use compare between the decode operands and the load in EX.
`default_nettype none

module pipe_hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic       rs1_used_i,
  input  logic       rs2_used_i,
  input  logic [4:0] rd_i,
  input  logic       is_load_i,
  output logic       lu_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = rs1_used_i && (rs1_i == rd_i);
  assign rs2_hit = rs2_used_i && (rs2_i == rd_i);
  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  assign lu_o    = is_load_i && (rd_i != REG_X0) && (rs1_hit || rs2_hit);

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencing for the 5-stage pipeline (load-use, branch, data-memory wait, ecall halt).
// Optional perf counters (stall_cycles, flush_events) are built when PIPE_HAZARD_PERF_EN is defined.
`default_nettype none

module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int unsigned CNT_W       = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        ex_branch_taken,
  input  logic        mem_access,
  input  logic        mem_ecall,
  input  logic        dm_ready,
  output logic        dm_req,
  output logic        stall_pc,
  output logic        stall_fd,
  output logic        stall_de,
  output logic        stall_em,
  output logic        flush_fd,
  output logic        flush_de,
  output logic        flush_em,
  output logic        bubble_mw,
  output logic        halt,
  output logic        mem_err
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_err_q, mem_err_d;
  logic             lu;

  logic dm_req_c, stall_pc_c, stall_fd_c, stall_de_c, stall_em_c;
  logic flush_fd_c, flush_de_c, flush_em_c, bubble_mw_c, halt_c;

  pipe_hazard_detect u_detect (
    .rs1_i      (id_rs1),
    .rs2_i      (id_rs2),
    .rs1_used_i (id_rs1_used),
    .rs2_used_i (id_rs2_used),
    .rd_i       (ex_rd),
    .is_load_i  (ex_is_load),
    .lu_o       (lu)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_err_d   = mem_err_q;
    dm_req_c    = 1'b0;
    stall_pc_c  = 1'b0;
    stall_fd_c  = 1'b0;
    stall_de_c  = 1'b0;
    stall_em_c  = 1'b0;
    flush_fd_c  = 1'b0;
    flush_de_c  = 1'b0;
    flush_em_c  = 1'b0;
    bubble_mw_c = 1'b0;
    halt_c      = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_ecall) begin
          state_d    = HALT;
          halt_c     = 1'b1;
          stall_pc_c = 1'b1;
          stall_fd_c = 1'b1;
          stall_de_c = 1'b1;
          flush_em_c = 1'b1;
        end else if (mem_access && !dm_ready) begin
          state_d     = MEM_WAIT;
          cnt_d       = CNT_W'(1);
          dm_req_c    = 1'b1;
          stall_pc_c  = 1'b1;
          stall_fd_c  = 1'b1;
          stall_de_c  = 1'b1;
          stall_em_c  = 1'b1;
          bubble_mw_c = 1'b1;
        end else begin
          dm_req_c = mem_access;
          // A taken branch squashes the younger instructions, so lu is moot
          if (ex_branch_taken) begin
            flush_fd_c = 1'b1;
            flush_de_c = 1'b1;
          end else if (lu) begin
            stall_pc_c = 1'b1;
            stall_fd_c = 1'b1;
            flush_de_c = 1'b1;
          end
        end
      end

      MEM_WAIT: begin
        dm_req_c    = 1'b1;
        stall_pc_c  = 1'b1;
        stall_fd_c  = 1'b1;
        stall_de_c  = 1'b1;
        stall_em_c  = 1'b1;
        bubble_mw_c = 1'b1;
        if (dm_ready) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(MEM_TIMEOUT)) begin
          // Abandon the access: drop the stuck instruction from E/M
          state_d    = RUN;
          cnt_d      = '0;
          mem_err_d  = 1'b1;
          flush_em_c = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      HALT: begin
        halt_c      = 1'b1;
        stall_pc_c  = 1'b1;
        stall_fd_c  = 1'b1;
        stall_de_c  = 1'b1;
        stall_em_c  = 1'b1;
        bubble_mw_c = 1'b1;
      end

      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Gate with rst so outputs fall the instant reset asserts, whatever the inputs
  assign dm_req    = rst && dm_req_c;
  assign stall_pc  = rst && stall_pc_c;
  assign stall_fd  = rst && stall_fd_c;
  assign stall_de  = rst && stall_de_c;
  assign stall_em  = rst && stall_em_c;
  assign flush_fd  = rst && flush_fd_c;
  assign flush_de  = rst && flush_de_c;
  assign flush_em  = rst && flush_em_c;
  assign bubble_mw = rst && bubble_mw_c;
  assign halt      = rst && halt_c;
  assign mem_err   = rst && mem_err_q;

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_events_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      if (stall_pc_c && (state_q != HALT) && (stall_cycles_q != 32'hFFFF_FFFF))
        stall_cycles_q <= stall_cycles_q + 32'd1;
      if (flush_fd_c && (flush_events_q != 32'hFFFF_FFFF))
        flush_events_q <= flush_events_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors with queued expectations checked by an independent monitor.
`default_nettype none

module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_rs1_used = 1'b0, id_rs2_used = 1'b0, ex_is_load = 1'b0;
  logic       ex_branch_taken = 1'b0, mem_access = 1'b0, mem_ecall = 1'b0, dm_ready = 1'b0;
  logic       dm_req, stall_pc, stall_fd, stall_de, stall_em;
  logic       flush_fd, flush_de, flush_em, bubble_mw, halt, mem_err;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
    .mem_access(mem_access), .mem_ecall(mem_ecall), .dm_ready(dm_ready),
    .dm_req(dm_req), .stall_pc(stall_pc), .stall_fd(stall_fd), .stall_de(stall_de),
    .stall_em(stall_em), .flush_fd(flush_fd), .flush_de(flush_de), .flush_em(flush_em),
    .bubble_mw(bubble_mw), .halt(halt), .mem_err(mem_err)
`ifdef PIPE_HAZARD_PERF_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
  );

  // {dm_req, stall_pc, stall_fd, stall_de, stall_em, flush_fd, flush_de, flush_em, bubble_mw, halt, mem_err}
  localparam logic [10:0] E_NONE  = 11'b000_0000_0000;
  localparam logic [10:0] E_LU    = 11'b011_0001_0000;
  localparam logic [10:0] E_BR    = 11'b000_0011_0000;
  localparam logic [10:0] E_ACC   = 11'b100_0000_0000;
  localparam logic [10:0] E_MW    = 11'b111_1100_0100;
  localparam logic [10:0] E_TO    = 11'b111_1100_1100;
  localparam logic [10:0] E_ECALL = 11'b011_1000_1010;
  localparam logic [10:0] E_HALT  = 11'b011_1100_0110;
  localparam logic [10:0] E_ERR   = 11'b000_0000_0001;

  logic [10:0] exp_q[$];
  string       name_q[$];
  int          n_vec = 0;
  int          n_bad = 0;

  wire [10:0] act = {dm_req, stall_pc, stall_fd, stall_de, stall_em,
                     flush_fd, flush_de, flush_em, bubble_mw, halt, mem_err};

  initial begin : monitor
    logic [10:0] e;
    string       nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_vec++;
        if (act !== e) begin
          n_bad++;
          $display("FAIL %s: got %b expected %b", nm, act, e);
        end
      end
    end
  end

  task automatic cyc(input logic [10:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_is_load = 1'b0;
    ex_branch_taken = 1'b0; mem_access = 1'b0; mem_ecall = 1'b0; dm_ready = 1'b0;
  endtask

  task automatic set_lu();
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
  endtask

  initial begin : stim
    @(posedge clk);
    #1;
    mem_access = 1'b1; mem_ecall = 1'b1; set_lu();
    cyc(E_NONE, "in_reset");
    rst = 1'b1; clr();
    cyc(E_NONE, "idle");

    set_lu();                                cyc(E_LU,   "lu_rs1");
    ex_is_load = 1'b0;                       cyc(E_NONE, "lu_released");
    set_lu(); ex_rd = 5'd0; id_rs1 = 5'd0;   cyc(E_NONE, "lu_x0");
    clr(); ex_is_load = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_rs2_used = 1'b1;
                                             cyc(E_LU,   "lu_rs2");
    id_rs2_used = 1'b0;                      cyc(E_NONE, "lu_rs2_unused");
    clr(); set_lu(); ex_branch_taken = 1'b1; cyc(E_BR,   "branch_over_lu");
    clr(); set_lu(); mem_access = 1'b1; dm_ready = 1'b1;
                                             cyc(E_ACC | E_LU, "zero_wait_lu");

    clr(); mem_access = 1'b1;                cyc(E_MW,   "wait3_start");
    ex_branch_taken = 1'b1; set_lu();        cyc(E_MW,   "wait3_w1");
                                             cyc(E_MW,   "wait3_w2");
    dm_ready = 1'b1;                         cyc(E_MW,   "wait3_done");
    clr();                                   cyc(E_NONE, "wait3_run");

    mem_access = 1'b1;                       cyc(E_MW,   "edge_start");
    repeat (3)                               cyc(E_MW,   "edge_wait");
    dm_ready = 1'b1;                         cyc(E_MW,   "edge_ready_at_limit");
    clr();                                   cyc(E_NONE, "edge_no_err");

    mem_access = 1'b1;                       cyc(E_MW,   "to_start");
    repeat (3)                               cyc(E_MW,   "to_wait");
                                             cyc(E_TO,   "to_abort");
    clr();                                   cyc(E_ERR,  "to_err_sticky");
    set_lu();                                cyc(E_LU | E_ERR, "to_back_in_run");

    clr(); mem_ecall = 1'b1;                 cyc(E_ECALL | E_ERR, "ecall");
    mem_ecall = 1'b0;                        cyc(E_HALT | E_ERR,  "halted");
    mem_access = 1'b1; ex_branch_taken = 1'b1;
                                             cyc(E_HALT | E_ERR,  "halt_absorbing");
    rst = 1'b0;                              cyc(E_NONE, "halt_reset");
    rst = 1'b1; clr();                       cyc(E_NONE, "after_halt_reset");

    mem_access = 1'b1;                       cyc(E_MW,   "rw_start");
                                             cyc(E_MW,   "rw_w1");
    rst = 1'b0;                              cyc(E_NONE, "rw_reset_async");
    rst = 1'b1; dm_ready = 1'b1;             cyc(E_ACC,  "rw_back_in_run");
    clr();                                   cyc(E_NONE, "rw_idle");

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage RISC-V pipeline.
- Drives the stall and flush inputs of the F/D, D/E and E/M pipeline registers, plus a bubble into M/W.
- Detects load-use hazards and taken branches, and sequences variable-latency data-memory accesses through a req/ready handshake with a timeout.
- Halts the core when an ecall reaches MEM.

Parameters:
MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before abort (>=1)
CNT_W, 5, width of wait counter; must hold MEM_TIMEOUT (clog2(MEM_TIMEOUT+1))

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-low reset
id_rs1  input  5  rs1 index of instruction in decode
id_rs2  input  5  rs2 index of instruction in decode
id_rs1_used  input  1  decode instruction reads rs1
id_rs2_used  input  1  decode instruction reads rs2
ex_rd  input  5  rd index held in D/E register
ex_is_load  input  1  D/E instruction is a load (wb_sel=1 and wb_en=1)
ex_branch_taken  input  1  EX resolved taken branch/jump
mem_access  input  1  E/M instruction is a load or has dm_w_en!=0
mem_ecall  input  1  ecall_sig from E/M register
dm_ready  input  1  data memory completes access this cycle
dm_req  output  1  data memory request
stall_pc  output  1  hold PC
stall_fd  output  1  hold F/D register
stall_de  output  1  hold D/E register
stall_em  output  1  hold E/M register
flush_fd  output  1  clear F/D control fields
flush_de  output  1  clear D/E control fields
flush_em  output  1  clear E/M control fields (drives E/M flush)
bubble_mw  output  1  clear M/W control fields
halt  output  1  core halted
mem_err  output  1  sticky data-memory timeout flag

Behaviour:
- FSM states: RUN, MEM_WAIT, HALT. State, wait counter and mem_err are reset asynchronously on rst low. Reset values: state=RUN, cnt=0, mem_err=0.
- While rst is low, every output is 0.
- All outputs are combinational functions of state, cnt and the inputs. State is updated on the posedge of clk.
- Load-use hazard, lu = ex_is_load & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
- RUN, in priority order:
  1. mem_ecall: next state HALT. Assert halt, stall_pc, stall_fd, stall_de, flush_em. dm_req=0.
  2. mem_access & !dm_ready: dm_req=1. Assert stall_pc, stall_fd, stall_de, stall_em and bubble_mw. Suppress all flush_*. Next state MEM_WAIT, cnt<=1.
  3. Otherwise dm_req=mem_access. Zero-wait access: completes this cycle, no stall.
- RUN branch/load-use handling, applied only when case 3 holds:
  - ex_branch_taken: flush_fd=1, flush_de=1. lu is ignored (the younger instructions are squashed).
  - Else if lu: stall_pc=1, stall_fd=1, flush_de=1. One bubble only: after one cycle ex_is_load refers to the bubble.
- MEM_WAIT:
  - dm_req=1. stall_pc, stall_fd, stall_de, stall_em and bubble_mw are asserted. All flush_* are 0.
  - Branch and lu are ignored; they re-evaluate in RUN because EX contents are frozen.
  - dm_ready: next state RUN, cnt<=0. That cycle still stalls, so the access completes with E/M held. The MEM result is captured by M/W on the next RUN cycle.
  - Else if cnt==MEM_TIMEOUT: next state RUN, mem_err<=1, cnt<=0. The access is abandoned: flush_em=1 that cycle and bubble_mw=1.
  - Else cnt<=cnt+1. The counter never wraps.
- HALT: absorbing until reset. halt=1; stall_pc, stall_fd, stall_de, stall_em=1; bubble_mw=1; dm_req=0.
- mem_err: sticky; cleared only by reset.
- Reset asserted mid-MEM_WAIT: return to RUN immediately. dm_req drops asynchronously.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- When defined: adds outputs stall_cycles[31:0] and flush_events[31:0].
  - stall_cycles increments every cycle stall_pc=1 and state!=HALT.
  - flush_events increments every cycle flush_fd=1.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- When undefined: the ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Shared pipeline package holds: the state encoding constants (RUN=2'd0, MEM_WAIT=2'd1, HALT=2'd2), the REG_X0 index constant, and MEM_TIMEOUT default.
- Natural sub-module: pipe_hazard_detect, a combinational lu compare, reusable if forwarding is added later.
- FSM, counter and perf counters stay in the top.

Test Plan:
- Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_rs1_used=1 -> one cycle of stall_pc=stall_fd=flush_de=1, then all 0 once ex_is_load=0. Repeat with ex_rd=0 -> no stall.
- Branch + load-use same cycle: ex_branch_taken=1 and lu=1 -> flush_fd=flush_de=1, stall_pc=0.
- Memory wait 3 cycles: mem_access=1, dm_ready low 3 cycles then high -> dm_req high 4 cycles, stall_em=1 for 4 cycles, back to RUN, mem_err=0.
- Timeout: MEM_TIMEOUT=4, dm_ready never high -> mem_err=1 after cycle 5 of the access, flush_em pulse, state RUN; mem_err stays 1 until rst.
- Ecall: mem_ecall=1 -> halt=1 next cycle and permanently; all stalls held; rst low->high clears halt.
- Reset mid-wait: rst low during MEM_WAIT -> all outputs 0 immediately; after release state RUN, cnt=0.
